// File: rtl/key_load_ctrl.sv
// Boot-time key sequencer for the logic-locked C432 core: reads key bytes plus a
// checksum byte from NVM, verifies them, and only then drives the core's keyinput bus.
module key_load_ctrl #(
  parameter int               KEY_W     = 29,
  parameter int               ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int               TIMEOUT   = 15,
  parameter int               MAX_RETRY = 2,
  parameter logic [7:0]       CHK_SALT  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              zeroize,
  output logic              nvm_req,
  output logic [ADDR_W-1:0] nvm_addr,
  input  logic              nvm_rvalid,
  input  logic [7:0]        nvm_rdata,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        retry_cnt
);

  localparam int NB    = (KEY_W + 7) / 8;
  localparam int IDX_W = $clog2(NB + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        chk_q, chk_d;
  logic [KEY_W-1:0]  staging_q, staging_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              kv_q, kv_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        retry_q, retry_d;

  logic last_byte;
  logic timeout_hit;
  logic chk_pass;
  logic can_retry;

  assign last_byte   = (idx_q == IDX_W'(NB));
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));
  assign chk_pass    = ((xor_q ^ CHK_SALT) == chk_q);
  assign can_retry   = (retry_q < 2'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (nvm_rvalid) begin
            if (last_byte) state_d = S_CHECK;
          end else if (timeout_hit) begin
            state_d = can_retry ? S_GAP : S_FAIL;
          end
        end
        S_CHECK: begin
          if (chk_pass) state_d = S_DONE;
          else          state_d = can_retry ? S_GAP : S_FAIL;
        end
        S_GAP:   state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    req_d     = req_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    xor_d     = xor_q;
    chk_d     = chk_q;
    staging_d = staging_q;
    key_d     = key_q;
    kv_d      = kv_q;
    err_d     = err_q;
    retry_d   = retry_q;
    if (zeroize) begin
      req_d     = 1'b0;
      addr_d    = BASE_ADDR;
      idx_d     = '0;
      tcnt_d    = '0;
      xor_d     = '0;
      chk_d     = '0;
      staging_d = '0;
      key_d     = '0;
      kv_d      = 1'b0;
      err_d     = 1'b0;
      retry_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            req_d     = 1'b1;
            addr_d    = BASE_ADDR;
            idx_d     = '0;
            tcnt_d    = '0;
            xor_d     = '0;
            chk_d     = '0;
            staging_d = '0;
            key_d     = '0;
            kv_d      = 1'b0;
            err_d     = 1'b0;
            retry_d   = '0;
          end
        end
        S_WAIT: begin
          if (nvm_rvalid) begin
            tcnt_d = '0;
            if (last_byte) begin
              chk_d = nvm_rdata;
              req_d = 1'b0;
            end else begin
              xor_d = xor_q ^ nvm_rdata;
              // Bits of the top byte beyond KEY_W never reach staging.
              for (int k = 0; k < KEY_W; k++) begin
                if (idx_q == IDX_W'(k / 8)) staging_d[k] = nvm_rdata[k % 8];
              end
              addr_d = addr_q + ADDR_W'(1);
              idx_d  = idx_q + IDX_W'(1);
            end
          end else if (timeout_hit) begin
            req_d = 1'b0;
            if (can_retry) begin
              retry_d = retry_q + 2'd1;
            end else begin
              err_d     = 1'b1;
              staging_d = '0;
              kv_d      = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_CHECK: begin
          if (chk_pass) begin
            key_d = staging_q;
            kv_d  = 1'b1;
          end else if (can_retry) begin
            retry_d = retry_q + 2'd1;
          end else begin
            err_d     = 1'b1;
            staging_d = '0;
            kv_d      = 1'b0;
          end
        end
        S_GAP: begin
          req_d     = 1'b1;
          addr_d    = BASE_ADDR;
          idx_d     = '0;
          tcnt_d    = '0;
          xor_d     = '0;
          staging_d = '0;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_WAIT) || (state_d == S_CHECK) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      addr_q    <= BASE_ADDR;
      idx_q     <= '0;
      tcnt_q    <= '0;
      xor_q     <= '0;
      chk_q     <= '0;
      staging_q <= '0;
      key_q     <= '0;
      kv_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= '0;
    end else begin
      req_q     <= req_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      xor_q     <= xor_d;
      chk_q     <= chk_d;
      staging_q <= staging_d;
      key_q     <= key_d;
      kv_q      <= kv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
    end
  end

  assign nvm_req   = req_q;
  assign nvm_addr  = addr_q;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: a vector table for plain loads, plus
// hand-written sequences for retries, timeout, zeroize and async reset.
module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic        nvm_rvalid = 1'b0;
  logic [7:0]  nvm_rdata = 8'h00;
  logic        nvm_req;
  logic [7:0]  nvm_addr;
  logic [28:0] key;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [1:0]  retry_cnt;

  int pass_count = 0;
  int check_count = 0;

  localparam logic [28:0] KEY_GOOD = 29'h1F563412;

  typedef struct {
    logic        start;
    logic        zer;
    logic        rv;
    logic [7:0]  rd;
    logic        ereq;
    logic [7:0]  eaddr;
    logic [28:0] ekey;
    logic        ekv;
    logic        ebusy;
    logic        eerr;
    logic [1:0]  eretry;
  } vec_t;

  vec_t vecs [15];

  key_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .zeroize    (zeroize),
    .nvm_req    (nvm_req),
    .nvm_addr   (nvm_addr),
    .nvm_rvalid (nvm_rvalid),
    .nvm_rdata  (nvm_rdata),
    .key        (key),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic z, input logic v, input logic [7:0] d);
    start      = s;
    zeroize    = z;
    nvm_rvalid = v;
    nvm_rdata  = d;
  endtask

  task automatic checkOutput(input string name, input logic ereq, input logic [7:0] eaddr,
                             input logic [28:0] ekey, input logic ekv, input logic ebusy,
                             input logic eerr, input logic [1:0] eretry);
    check_count++;
    if (nvm_req === ereq && nvm_addr === eaddr && key === ekey && key_valid === ekv &&
        busy === ebusy && err === eerr && retry_cnt === eretry) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got req=%0b addr=%02h key=%08h valid=%0b busy=%0b err=%0b retry=%0d, want req=%0b addr=%02h key=%08h valid=%0b busy=%0b err=%0b retry=%0d",
               name, nvm_req, nvm_addr, key, key_valid, busy, err, retry_cnt,
               ereq, eaddr, ekey, ekv, ebusy, eerr, eretry);
    end
  endtask

  // Feeds one full attempt (4 key bytes + checksum) and leaves the DUT in CHECK.
  task automatic runAttempt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] c, input logic [1:0] r,
                            input string tag);
    logic [7:0] bytes [4];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    bytes[3] = b3;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, bytes[i]);
      step();
      checkOutput($sformatf("%s byte%0d", tag, i), 1'b1, 8'(i + 1), 29'h0, 1'b0, 1'b1, 1'b0, r);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, c);
    step();
    checkOutput({tag, " chk"}, 1'b0, 8'h04, 29'h0, 1'b0, 1'b1, 1'b0, r);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Good load, a stray rvalid in DONE, then a masked top byte:
    // checksum 0x12^0x34^0x56^0xFF^0xA5 = 0x2A.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 8'h01, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 8'h02, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 8'h03, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h1F, 1'b1, 8'h04, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hCA, 1'b0, 8'h04, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, KEY_GOOD, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h04, KEY_GOOD, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 8'h01, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 8'h02, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 8'h03, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h04, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 8'h04, 29'h0,    1'b0, 1'b1, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, KEY_GOOD, 1'b1, 1'b0, 1'b0, 2'd0};

    #3;
    checkOutput("reset state", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("idle after reset", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].start, vecs[i].zer, vecs[i].rv, vecs[i].rd);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].ekey,
                  vecs[i].ekv, vecs[i].ebusy, vecs[i].eerr, vecs[i].eretry);
    end

    // Zeroize in DONE with a simultaneous start, then a late rvalid.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("zeroize in done", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("start under zeroize ignored", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAB);
    step();
    checkOutput("late rvalid in idle", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Zeroize mid-WAIT while byte 1 is arriving.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("zw start", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
    step();
    checkOutput("zw byte0", 1'b1, 8'h01, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h34);
    step();
    checkOutput("zeroize mid wait", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("zw stays idle", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Bad checksum on all three attempts.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("bad start", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    runAttempt(8'h12, 8'h34, 8'h56, 8'h1F, 8'h00, 2'd0, "bad a1");
    step();
    checkOutput("bad gap1", 1'b0, 8'h04, 29'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    step();
    checkOutput("bad restart2", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    runAttempt(8'h12, 8'h34, 8'h56, 8'h1F, 8'h00, 2'd1, "bad a2");
    step();
    checkOutput("bad gap2", 1'b0, 8'h04, 29'h0, 1'b0, 1'b1, 1'b0, 2'd2);
    step();
    checkOutput("bad restart3", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd2);
    runAttempt(8'h12, 8'h34, 8'h56, 8'h1F, 8'h00, 2'd2, "bad a3");
    step();
    checkOutput("bad final fail", 1'b0, 8'h04, 29'h0, 1'b0, 1'b0, 1'b1, 2'd2);
    step();
    checkOutput("err sticky", 1'b0, 8'h04, 29'h0, 1'b0, 1'b0, 1'b1, 2'd2);

    // Timeout on byte 2 of the first attempt, then a clean second attempt.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("to start clears err", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
    step();
    checkOutput("to byte1", 1'b1, 8'h02, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) step();
    checkOutput("to 14 idle cycles", 1'b1, 8'h02, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    checkOutput("to 15th cycle gap", 1'b0, 8'h02, 29'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    step();
    checkOutput("to restart addr0", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    runAttempt(8'h12, 8'h34, 8'h56, 8'h1F, 8'hCA, 2'd1, "to a2");
    step();
    checkOutput("to done", 1'b0, 8'h04, KEY_GOOD, 1'b1, 1'b0, 1'b0, 2'd1);

    // Start while busy, then async reset mid-WAIT and a late rvalid.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("rb start", 1'b1, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("start while busy no rvalid", 1'b1, 8'h01, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h34);
    step();
    checkOutput("start while busy with rvalid", 1'b1, 8'h02, 29'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset mid wait", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h56);
    step();
    checkOutput("late rvalid after reset", 1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
